instr_fetch_unit: RTL and testbench

Fetch stage placed directly upstream of the CPU's decode/execute datapath. It owns the fetch PC, issues word reads to instruction memory over a req/ack handshake that tolerates variable latency, and buffers returned instructions with their PCs in a small FIFO. It presents them to the consumer over a valid/ready interface. Branch/jump redirects flush the buffer and restart fetch; an outstanding memory read that cannot be aborted is completed and its data discarded.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/inst_fifo.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Fetch FSM states, buffer entry layout, PC helpers.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small instruction buffer of {pc, inst} entries.
// Flush beats push and pop; head reads as zero when empty.
module inst_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);

  // Pointers and occupancy; flush empties in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // Entry storage needs no reset; empty head is masked.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/ack, redirect handling.
// Feeds the decode stage from a small instruction buffer.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_state_t     state;
  fetch_state_t     state_nx;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_nx;
  logic [31:0]      hold_addr;
  logic [31:0]      hold_addr_nx;
  logic             push;
  logic             pop;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] post_cnt;
  fetch_entry_t     head;
  fetch_entry_t     din;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign post_cnt   = count + CNT_W'(1) - CNT_W'(pop);
  assign din        = '{pc: fetch_pc, inst: imem_rdata};

  // State, fetch PC and the abandoned address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
    end else begin
      state     <= state_nx;
      fetch_pc  <= fetch_pc_nx;
      hold_addr <= hold_addr_nx;
    end
  end

  // Next state; redirect wins over everything.
  always_comb begin
    state_nx     = state;
    fetch_pc_nx  = fetch_pc;
    hold_addr_nx = hold_addr;
    push         = 1'b0;
    flush        = 1'b0;
    if (redirect_valid) begin
      flush       = 1'b1;
      fetch_pc_nx = word_align(redirect_pc);
      if (state != IDLE && !imem_ack) begin
        state_nx = DISCARD;
        if (state == REQ) hold_addr_nx = fetch_pc;
      end else begin
        state_nx = IDLE;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (count < FULL) state_nx = REQ;
        end
        REQ: begin
          if (imem_ack) begin
            push        = 1'b1;
            fetch_pc_nx = fetch_pc + 32'd4;
            state_nx    = (post_cnt < FULL) ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (imem_ack) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign imem_req  = (state == REQ) || (state == DISCARD);
  assign imem_addr = (state == DISCARD) ? hold_addr : fetch_pc;

  inst_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(reset_n),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (din),
    .count(count),
    .head (head)
  );

  assign inst_data     = head.inst;
  assign inst_pc       = head.pc;
  assign inst_pc_plus4 = head.pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Expected PCs queued per scenario; popped on each consumer handshake.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  bit          mem_auto;
  int          lat;
  int          wcnt;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_pc_plus4 (inst_pc_plus4)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // Memory model: data always follows the address; ack after lat waits.
  always @(negedge clk) begin
    imem_rdata = mem_f(imem_addr);
    if (mem_auto) begin
      if (imem_req) begin
        if (wcnt == lat) begin
          imem_ack = 1'b1;
          wcnt = 0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Scoreboard: every accepted instruction must match the queue head.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset_n && inst_valid && inst_ready && !redirect_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra got pc=%h want none", inst_pc);
      end else begin
        e = sb.pop_front();
        if (inst_pc !== e || inst_data !== mem_f(e) ||
            inst_pc_plus4 !== e + 32'd4) begin
          errors++;
          $display("FAIL sb_item got pc=%h d=%h p4=%h want pc=%h d=%h p4=%h",
                   inst_pc, inst_data, inst_pc_plus4,
                   e, mem_f(e), e + 32'd4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input bit auto_m, input int l);
    reset_n        = 1'b0;
    inst_ready     = rdy;
    mem_auto       = auto_m;
    lat            = l;
    wcnt           = 0;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    inst_ready     = 1'b1;
    mem_auto       = 1'b1;
    lat            = 0;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_req got req=%b addr=%h want 0 0",
               imem_req, imem_addr);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_valid got v=%b d=%h want 0 0",
               inst_valid, inst_data);
    end
    checks++;
    if (inst_pc !== 32'h0 || inst_pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL rst_pc got pc=%h p4=%h want 0 4",
               inst_pc, inst_pc_plus4);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1, 0);
    for (int i = 0; i < 7; i++) sb.push_back(32'(4 * i));
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_addr got req=%b addr=%h want 1 %h",
                 imem_req, imem_addr, 32'(4 * i));
      end
    end
    @(posedge clk);
    #1;
    inst_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stream_drain got left=%0d want 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0, 1'b1, 0);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    sb.push_back(32'h8);
    sb.push_back(32'hc);
    sb.push_back(32'h10);
    repeat (4) tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h8 ||
        inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_full got req=%b addr=%h v=%b pc=%h want 0 8 1 0",
               imem_req, imem_addr, inst_valid, inst_pc);
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 ||
            inst_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_rereq got req=%b addr=%h v=%b want 1 8 0",
                   imem_req, imem_addr, inst_valid);
        end
      end
      @(posedge clk);
    end
    #1;
    inst_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got left=%0d want 0", sb.size());
    end
  endtask

  task automatic test_latency();
    do_reset(1'b0, 1'b1, 3);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 ||
          inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL lat_hold%0d got req=%b addr=%h v=%b want 1 0 0",
                 i, imem_req, imem_addr, inst_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 ||
        inst_data !== mem_f(32'h0) || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL lat_push got v=%b pc=%h d=%h addr=%h want 1 0 %h 4",
               inst_valid, inst_pc, inst_data, imem_addr, mem_f(32'h0));
    end
  endtask

  task automatic test_redirect_discard();
    do_reset(1'b1, 1'b0, 0);
    sb.push_back(32'h0);
    sb.push_back(32'h40);
    tick();
    imem_ack = 1'b1;
    tick();
    tick();
    imem_ack   = 1'b0;
    inst_ready = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_pre got req=%b addr=%h v=%b want 1 8 1",
               imem_req, imem_addr, inst_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL rd_disc got v=%b req=%b addr=%h want 0 1 8",
               inst_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL rd_hold got req=%b addr=%h want 1 8",
               imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_drop got req=%b v=%b want 0 0",
               imem_req, inst_valid);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL rd_new got req=%b addr=%h want 1 40",
               imem_req, imem_addr);
    end
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rd_drain got left=%0d want 0", sb.size());
    end
  endtask

  task automatic test_redirect_ack();
    do_reset(1'b1, 1'b0, 0);
    sb.push_back(32'h0);
    sb.push_back(32'h100);
    tick();
    imem_ack = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL ra_pre got req=%b addr=%h want 1 8",
               imem_req, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL ra_idle got req=%b v=%b want 0 0",
               imem_req, inst_valid);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL ra_new got req=%b addr=%h want 1 100",
               imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL ra_drain got left=%0d want 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0, 1'b1, 0);
    sb.push_back(32'hffff_fffc);
    sb.push_back(32'h0);
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_fffe;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_flush got v=%b want 0", inst_valid);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hffff_fffc) begin
      errors++;
      $display("FAIL wr_req got req=%b addr=%h want 1 fffffffc",
               imem_req, imem_addr);
    end
    tick();
    checks++;
    if (imem_addr !== 32'h0 || inst_pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wr_wrap got addr=%h p4=%h want 0 0",
               imem_addr, inst_pc_plus4);
    end
    tick();
    tick();
    inst_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wr_drain got left=%0d want 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0, 1'b1, 1);
    repeat (4) tick();
    checks++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL ar_pre got req=%b v=%b addr=%h want 1 1 4",
               imem_req, inst_valid, imem_addr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 ||
        imem_addr !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL ar_async got req=%b v=%b addr=%h pc=%h want 0 0 0 0",
               imem_req, inst_valid, imem_addr, inst_pc);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL ar_restart got req=%b addr=%h want 1 0",
               imem_req, imem_addr);
    end
  endtask

  initial begin
    mem_auto   = 1'b0;
    lat        = 0;
    wcnt       = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_latency();
    test_redirect_discard();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
